// File: rtl/add_sub_pkg.sv
// ---------------------------------------------------------------------------
// add_sub_pkg
// Shared definitions for the sequential add/subtract/compare unit.
//   state_e   : controller states (IDLE / CALC / DONE)
//   cnt_width : width of a counter able to index n slices (at least 1 bit)
// ---------------------------------------------------------------------------
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_slice.sv
// ---------------------------------------------------------------------------
// add_slice
// One W-bit ripple slice of the sequential adder.
//   a_i, b_i : slice operands (b_i is already inverted when subtracting)
//   cin_i    : carry into the slice
//   sum_o    : slice sum bits
//   cout_o   : carry out of the slice
//   zero_o   : high when all sum bits are zero
// ---------------------------------------------------------------------------
module add_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         zero_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
    assign zero_o          = (sum_o == '0);

endmodule

// File: rtl/add_sub_comp_seq.sv
// ---------------------------------------------------------------------------
// add_sub_comp_seq
// Sequential add / subtract / compare unit. The (DATA_W+1)-bit operation is
// performed SLICE_W bits per clock, LSB slice first, using a single reused
// add_slice instance. Results are published together on the completing edge.
//
// Ports
//   clk_i, rst_ni           : clock (rising edge), async active-low reset
//   in_valid_i / in_ready_o : request handshake
//   oprand_a_i, oprand_b_i  : operands
//   sub_sel_i               : 1 = A-B, 0 = A+B
//   unsigned_sel_i          : 1 = unsigned operands, 0 = two's complement
//   out_valid_o/out_ready_i : response handshake
//   result_o                : low DATA_W bits of the result
//   less_o                  : sign (extension) bit of the extended result
//   equal_o                 : whole extended result is zero
//   state_o                 : controller state, for observation
//   overflow_o              : only when ADD_SUB_COMP_SEQ_OVF_EN is defined
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds with its payload stable until that
// edge; ready may depend combinationally on the partner's signals.
// ---------------------------------------------------------------------------
module add_sub_comp_seq
    import add_sub_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] oprand_a_i,
    input  logic [DATA_W-1:0] oprand_b_i,
    input  logic              sub_sel_i,
    input  logic              unsigned_sel_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              less_o,
    output logic              equal_o,
    output logic [1:0]        state_o
`ifdef ADD_SUB_COMP_SEQ_OVF_EN
    ,
    output logic              overflow_o
`endif
);

    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int CNT_W  = cnt_width(NSLICE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    generate
        if ((SLICE_W <= 0) || ((DATA_W % SLICE_W) != 0)) begin : g_bad_cfg
            $error("add_sub_comp_seq: DATA_W must be a multiple of SLICE_W");
        end
    endgenerate

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                sub_q, sub_d;
    logic                uns_q, uns_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                carry_q, carry_d;
    logic                zero_q, zero_d;
    logic [DATA_W-1:0]   acc_q, acc_d;      // partial sums, hidden until done
    logic [DATA_W-1:0]   result_q, result_d;
    logic                less_q, less_d;
    logic                equal_q, equal_d;
`ifdef ADD_SUB_COMP_SEQ_OVF_EN
    logic                ovf_q, ovf_d;
`endif

    logic                accept;
    logic                last_slice;
    int                  base;
    logic [SLICE_W-1:0]  sl_a, sl_b, sl_sum;
    logic                sl_cout, sl_zero;
    logic                ext_a, ext_b, ext_bit;

    // Output process of the controller
    assign in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
    assign out_valid_o = (state_q == DONE);
    assign state_o     = state_q;
    assign accept      = in_valid_i && in_ready_o;
    assign last_slice  = (state_q == CALC) && (cnt_q == LAST_CNT);

    // Slice operand selection; B is inverted for subtraction (carry-in = 1)
    always_comb begin
        base = int'(cnt_q) * SLICE_W;
        sl_a = a_q[base +: SLICE_W];
        sl_b = b_q[base +: SLICE_W] ^ {SLICE_W{sub_q}};
    end

    add_slice #(.W(SLICE_W)) u_slice (
        .a_i    (sl_a),
        .b_i    (sl_b),
        .cin_i  (carry_q),
        .sum_o  (sl_sum),
        .cout_o (sl_cout),
        .zero_o (sl_zero)
    );

    // Bit DATA_W of the extended add: extension of A, extension of B'
    // (inverted when subtracting) and the carry out of the top slice.
    assign ext_a   = ~uns_q & a_q[DATA_W-1];
    assign ext_b   = (~uns_q & b_q[DATA_W-1]) ^ sub_q;
    assign ext_bit = ext_a ^ ext_b ^ sl_cout;

    // Next-state process
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = CALC;
            CALC: if (last_slice) state_d = DONE;
            DONE: if (out_ready_i) state_d = in_valid_i ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        uns_d    = uns_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        acc_d    = acc_q;
        result_d = result_q;
        less_d   = less_q;
        equal_d  = equal_q;
`ifdef ADD_SUB_COMP_SEQ_OVF_EN
        ovf_d    = ovf_q;
`endif
        if (accept) begin
            a_d     = oprand_a_i;
            b_d     = oprand_b_i;
            sub_d   = sub_sel_i;
            uns_d   = unsigned_sel_i;
            cnt_d   = '0;
            carry_d = sub_sel_i;
            zero_d  = 1'b1;
        end else if (state_q == CALC) begin
            acc_d[base +: SLICE_W] = sl_sum;
            carry_d = sl_cout;
            zero_d  = zero_q & sl_zero;
            cnt_d   = cnt_q + 1'b1;
            if (last_slice) begin
                cnt_d    = '0;
                result_d = acc_d;
                less_d   = ext_bit;
                equal_d  = zero_q & sl_zero & ~ext_bit;
`ifdef ADD_SUB_COMP_SEQ_OVF_EN
                // Signed: sign of true result differs from result MSB.
                // Unsigned: carry-out on add, borrow on subtract.
                ovf_d    = uns_q ? ext_bit : (ext_bit ^ sl_sum[SLICE_W-1]);
`endif
            end
        end
    end

    // State register and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            uns_q    <= 1'b0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            less_q   <= 1'b0;
            equal_q  <= 1'b0;
`ifdef ADD_SUB_COMP_SEQ_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            uns_q    <= uns_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            less_q   <= less_d;
            equal_q  <= equal_d;
`ifdef ADD_SUB_COMP_SEQ_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign result_o = result_q;
    assign less_o   = less_q;
    assign equal_o  = equal_q;
`ifdef ADD_SUB_COMP_SEQ_OVF_EN
    assign overflow_o = ovf_q;
`endif

endmodule

// File: tb/tb_add_sub_comp_seq.sv
// ---------------------------------------------------------------------------
// tb_add_sub_comp_seq
// Self-checking bench for add_sub_comp_seq (DATA_W=32, SLICE_W=8).
// Build with ADD_SUB_COMP_SEQ_OVF_EN defined to also check overflow_o.
// ---------------------------------------------------------------------------
module tb_add_sub_comp_seq;

    localparam int DATA_W = 32;
    localparam int NSLICE = 4;
    localparam int EW     = DATA_W + 3;   // {ovf, equal, less, result}

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [DATA_W-1:0] oprand_a_i = '0;
    logic [DATA_W-1:0] oprand_b_i = '0;
    logic              sub_sel_i = 1'b0;
    logic              unsigned_sel_i = 1'b0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b1;
    logic [DATA_W-1:0] result_o;
    logic              less_o;
    logic              equal_o;
    logic [1:0]        state_o;
    logic              ovf_obs;
`ifdef ADD_SUB_COMP_SEQ_OVF_EN
    logic              overflow_o;
    assign ovf_obs = overflow_o;
`else
    assign ovf_obs = 1'b0;
`endif

    add_sub_comp_seq #(.DATA_W(DATA_W), .SLICE_W(8)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .oprand_a_i     (oprand_a_i),
        .oprand_b_i     (oprand_b_i),
        .sub_sel_i      (sub_sel_i),
        .unsigned_sel_i (unsigned_sel_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .result_o       (result_o),
        .less_o         (less_o),
        .equal_o        (equal_o),
        .state_o        (state_o)
`ifdef ADD_SUB_COMP_SEQ_OVF_EN
        ,
        .overflow_o     (overflow_o)
`endif
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc = cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            acc_cyc_q[$];
    int            checks = 0;
    int            failures = 0;
    logic          rdy_rand = 1'b0;
    logic          hold_req = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: exact integer arithmetic on the extended operands,
    // then the (DATA_W+1)-bit two's complement view of the true result.
    function automatic logic [EW-1:0] model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sub, input logic uns);
        longint     ea, eb, r;
        logic [63:0] rv;
        logic       ovf;
        ea = uns ? longint'({32'b0, a}) : longint'($signed(a));
        eb = uns ? longint'({32'b0, b}) : longint'($signed(b));
        r  = sub ? (ea - eb) : (ea + eb);
        rv = r;
        if (uns) ovf = (r < 0) || (r > 64'sh0000_0000_FFFF_FFFF);
        else     ovf = (r < -64'sh8000_0000) || (r > 64'sh7FFF_FFFF);
        return {ovf, (rv[32:0] == 33'd0), rv[32], rv[31:0]};
    endfunction

    // ---------------- driver ----------------
    task automatic do_req(input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic uns);
        int waited = 0;
        @(negedge clk_i);
        in_valid_i     = 1'b1;
        oprand_a_i     = a;
        oprand_b_i     = b;
        sub_sel_i      = sub;
        unsigned_sel_i = uns;
        #1;
        while (!in_ready_o && waited < 200) begin
            @(negedge clk_i);
            #1;
            waited++;
        end
        if (!in_ready_o) begin
            check("accept_timeout", 64'(waited), 64'd0);
            in_valid_i = 1'b0;
        end else begin
            @(posedge clk_i);
            #1;
            exp_q.push_back(model(a, b, sub, uns));
            acc_cyc_q.push_back(cyc);
            in_valid_i     = 1'b0;
            oprand_a_i     = $urandom;   // must be ignored during CALC
            oprand_b_i     = $urandom;
            sub_sel_i      = $urandom_range(0, 1);
            unsigned_sel_i = $urandom_range(0, 1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- monitor ----------------
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b1;
    int            hold_cnt = 0;
    logic [EW-1:0] snap;

    initial begin
        logic [EW-1:0] e;
        logic [EW-1:0] obs;
        forever begin
            @(negedge clk_i);
            if (hold_req && out_valid_o && hold_cnt == 0) begin
                hold_cnt = 3;
                hold_req = 1'b0;
            end
            if (hold_cnt > 0) begin
                out_ready_i = 1'b0;
                hold_cnt--;
            end else begin
                out_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            #2;
            obs = {ovf_obs, equal_o, less_o, result_o};
`ifndef ADD_SUB_COMP_SEQ_OVF_EN
            obs[EW-1] = 1'b0;
`endif
            if (out_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    if (!prev_valid)
                        check("latency", 64'(cyc - acc_cyc_q[0]), 64'(NSLICE));
                    if (prev_valid && !prev_ready)
                        check("hold_stable", 64'(obs), 64'(snap));
                    if (out_ready_i) begin
                        e = exp_q.pop_front();
                        void'(acc_cyc_q.pop_front());
                        check("result", 64'(result_o), 64'(e[DATA_W-1:0]));
                        check("less", 64'(less_o), 64'(e[DATA_W]));
                        check("equal", 64'(equal_o), 64'(e[DATA_W+1]));
`ifdef ADD_SUB_COMP_SEQ_OVF_EN
                        check("overflow", 64'(overflow_o), 64'(e[DATA_W+2]));
`endif
                    end else begin
                        snap = obs;
                        check("in_ready_while_held", 64'(in_ready_o), 64'd0);
                    end
                end
            end
            prev_valid = out_valid_o;
            prev_ready = out_ready_i;
        end
    end

    // ---------------- main sequence ----------------
    logic [31:0] corner [8] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                               32'h8000_0000, 32'h0000_00FF, 32'hFF00_0000, 32'h1234_5678};

    initial begin
        logic saw_valid;
        // reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_result", 64'(result_o), 64'd0);
        check("rst_flags", 64'({less_o, equal_o, ovf_obs}), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("in_ready_after_reset", 64'(in_ready_o), 64'd1);

        // directed cases
        do_req(32'd5, 32'd3, 1'b1, 1'b0);
        do_req(32'h1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        do_req(32'h1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_req(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0);
        do_req(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
        do_req(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        drain();

        // output held in DONE, then back-to-back accept on release
        hold_req = 1'b1;
        do_req(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1);
        do_req(32'h8000_0000, 32'h1, 1'b1, 1'b0);
        drain();

        // reset pulse during CALC slice 2
        do_req(32'hAAAA_5555, 32'h1111_2222, 1'b0, 1'b0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        exp_q.delete();
        acc_cyc_q.delete();
        #1;
        check("midcalc_rst_outputs",
              64'({out_valid_o, less_o, equal_o, ovf_obs}), 64'd0);
        check("midcalc_rst_result", 64'(result_o), 64'd0);
        check("midcalc_rst_state", 64'(state_o), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("in_ready_after_midrst", 64'(in_ready_o), 64'd1);
        saw_valid = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            if (out_valid_o) saw_valid = 1'b1;
        end
        check("no_stale_valid", 64'(saw_valid), 64'd0);
        do_req(32'd100, 32'd58, 1'b1, 1'b0);
        drain();

        // randomized traffic with random backpressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 7)] : $urandom;
            b = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 7)] : $urandom;
            if ($urandom_range(0, 5) == 0) b = a;
            do_req(a, b, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
        end
        drain();
        rdy_rand = 1'b0;
        repeat (3) @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
